inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the instruction decode stage: accepts decoded RV32I fields and packs them into a 32-bit instruction word.
- Used by the self-check / trace path and the instruction-memory preload bench to regenerate machine code from field records.
- Decode-then-encode must reproduce the original word for every legal instruction.
- Two-stage valid/ready pipeline: stage A classifies and checks legality, stage B assembles and holds the result. Flags illegal field combinations and counts them.

Parameters:
- CNT_W, 16, width of the saturating illegal-record counter.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  field record present
- in_ready  out  1  encoder accepts record this cycle
- in_pc  in  32  pc carried alongside the record
- in_opcode  in  7  opcode field
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_imm  in  32  immediate, in decoded (extended) form
- in_shamt  in  5  shift amount for slli/srli/srai
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_inst  out  32  encoded instruction; 32'h0 when illegal
- out_pc  out  32  pc passed through
- out_illegal  out  1  record failed legality check
- illegal_cnt  out  CNT_W  saturating count of illegal records emitted

Behaviour:
- Reset (reset_n low at an edge): a_valid, out_valid, out_inst, out_pc, out_illegal and illegal_cnt all go to 0. Records in flight are discarded. in_ready is 1 in the first cycle after reset.
- Transfer occurs on a cycle where valid and ready are both 1.
- b_adv = !out_valid || out_ready.
- a_adv = a_valid && b_adv.
- in_ready = !a_valid || b_adv (combinational, full throughput).
- Latency: a record accepted at edge N appears on out_* after edge N+1. Sustained throughput is 1 per cycle.
- While out_valid && !out_ready, out_* are held stable. Stage A holds, then in_ready drops. No record is lost or duplicated.
- Stage A registers the fields, a 3-bit format code (R, I, ISHIFT, S, B, U, J, BAD) and a legal bit.
- Format by opcode:
  - 0110011 → R
  - 0010011 with funct3 001/101 → ISHIFT
  - 0010011 with any other funct3 → I
  - 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → BAD
- Legality (illegal if any fails):
  - BAD format is always illegal.
  - I/S: in_imm[31:11] all equal.
  - B: in_imm[31:12] all equal, and in_imm[0]=0.
  - U: in_imm[11:0]=0.
  - J: in_imm[31:21]=0 and in_imm[0]=0. The JAL immediate is zero-extended 21-bit in the decoded form.
  - ISHIFT: funct3 001 needs funct7=0000000. funct3 101 needs funct7 of 0000000 or 0100000.
  - Fields unused by a format (e.g. rs2 for I-type) are ignored, not checked.
- Stage B assembly (standard RV32I bit placement):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - ISHIFT: {funct7, shamt, rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Illegal record: out_inst=0, out_illegal=1, out_pc still passed through.
- illegal_cnt increments by 1 at the B-stage load of an illegal record. It saturates at all-ones and does not wrap.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM)
  - format enum FMT_R..FMT_BAD
  - funct7 constants F7_BASE = 0000000 and F7_ALT = 0100000
- The decode stage also uses this package.
- One sub-module, enc_classify: combinational opcode/funct3/funct7/imm → format + legal. Stage A instantiates it. The pipeline registers, handshake and assembly stay in inst_encoder.

Test Plan:
- addi x1,x0,5 (op 0010011, rd 1, rs1 0, f3 0, imm 5) → out_inst 0x00500093, illegal 0, two edges after acceptance.
- add x3,x1,x2 → 0x002081B3; sw x2,8(x1) → 0x0020A423; beq x1,x2,imm 0xFFFFFFFC → 0xFE208EE3.
- lui x5 with imm 0x12345000 → 0x123452B7; srai x4,x3,2 (funct7 0100000, shamt 2) → 0x4021D213.
- Illegal cases, then opcode 0000000:
  - Inputs: B with imm 0x00000003; U with imm 0x00000001; opcode 0000000.
  - Required: each gives out_inst 0, out_illegal 1, with illegal_cnt stepping to 1, 2, 3.
  - With CNT_W forced to 2: the count stays at 3 after a 4th illegal record.
- Back-to-back stream of 4 records with out_ready held low for 3 cycles:
  - Required: in_ready falls once A and B are both full, out_* stay stable, and all 4 words emerge in order with no gaps once out_ready=1.
- reset_n low for one cycle with both stages full:
  - Required: out_valid=0 and illegal_cnt=0 next cycle, and a new record is accepted immediately after.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding definitions for the decode and encode stages.
// Holds opcode and funct7 constants, the instruction format enum and the field-record type.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_ISHIFT,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [4:0]  shamt;
  } fields_t;

endpackage

// File: rtl/enc_classify.sv
// Combinational classifier: maps opcode/funct3 to an instruction format and checks
// that the decoded immediate and funct7 can be represented in that format.
module enc_classify
  import rv32_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output fmt_e        fmt,
  output logic        legal
);

  logic imm12_ok;
  logic imm13_ok;

  // Sign-extended immediates must have every bit above the field equal to the field's sign bit.
  assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign imm13_ok = (imm[31:12] == '0) || (imm[31:12] == '1);

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OP_R:      fmt = FMT_R;
      OP_IMM:    fmt = ((funct3 == F3_SLL) || (funct3 == F3_SRX)) ? FMT_ISHIFT : FMT_I;
      OP_LOAD,
      OP_JALR,
      OP_SYSTEM: fmt = FMT_I;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_LUI,
      OP_AUIPC:  fmt = FMT_U;
      OP_JAL:    fmt = FMT_J;
      default:   fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (fmt)
      FMT_R:      legal = 1'b1;
      FMT_I,
      FMT_S:      legal = imm12_ok;
      FMT_B:      legal = imm13_ok && !imm[0];
      FMT_U:      legal = (imm[11:0] == '0);
      FMT_J:      legal = (imm[31:21] == '0) && !imm[0];
      FMT_ISHIFT: legal = (funct7 == F7_BASE) || ((funct3 == F3_SRX) && (funct7 == F7_ALT));
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I field-record to machine-code encoder: two-stage valid/ready pipeline
// (A: classify + legality, B: assemble + hold) with a saturating illegal-record counter.
module inst_encoder
  import rv32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  fields_t in_rec;
  fmt_e    cls_fmt;
  logic    cls_legal;

  logic    a_valid_q, a_valid_d;
  fields_t a_rec_q, a_rec_d;
  fmt_e    a_fmt_q, a_fmt_d;
  logic    a_legal_q, a_legal_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic        b_adv;
  logic        a_adv;
  logic        in_fire;
  logic [31:0] inst_asm;

  assign b_adv    = !out_valid_q || out_ready;
  assign a_adv    = a_valid_q && b_adv;
  assign in_ready = !a_valid_q || b_adv;
  assign in_fire  = in_valid && in_ready;

  assign in_rec = '{pc: in_pc, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm, shamt: in_shamt};

  enc_classify u_classify (
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .fmt    (cls_fmt),
    .legal  (cls_legal)
  );

  // ---- stage A: capture record with its format and legality ----
  always_comb begin
    a_valid_d = a_valid_q;
    a_rec_d   = a_rec_q;
    a_fmt_d   = a_fmt_q;
    a_legal_d = a_legal_q;
    if (in_ready) begin
      a_valid_d = in_valid;
    end
    if (in_fire) begin
      a_rec_d   = in_rec;
      a_fmt_d   = cls_fmt;
      a_legal_d = cls_legal;
    end
  end

  // ---- stage A -> B: standard RV32I bit placement ----
  always_comb begin
    inst_asm = 32'h0;
    case (a_fmt_q)
      FMT_R:      inst_asm = {a_rec_q.funct7, a_rec_q.rs2, a_rec_q.rs1, a_rec_q.funct3,
                              a_rec_q.rd, a_rec_q.opcode};
      FMT_I:      inst_asm = {a_rec_q.imm[11:0], a_rec_q.rs1, a_rec_q.funct3,
                              a_rec_q.rd, a_rec_q.opcode};
      FMT_ISHIFT: inst_asm = {a_rec_q.funct7, a_rec_q.shamt, a_rec_q.rs1, a_rec_q.funct3,
                              a_rec_q.rd, a_rec_q.opcode};
      FMT_S:      inst_asm = {a_rec_q.imm[11:5], a_rec_q.rs2, a_rec_q.rs1, a_rec_q.funct3,
                              a_rec_q.imm[4:0], a_rec_q.opcode};
      FMT_B:      inst_asm = {a_rec_q.imm[12], a_rec_q.imm[10:5], a_rec_q.rs2, a_rec_q.rs1,
                              a_rec_q.funct3, a_rec_q.imm[4:1], a_rec_q.imm[11], a_rec_q.opcode};
      FMT_U:      inst_asm = {a_rec_q.imm[31:12], a_rec_q.rd, a_rec_q.opcode};
      FMT_J:      inst_asm = {a_rec_q.imm[20], a_rec_q.imm[10:1], a_rec_q.imm[11],
                              a_rec_q.imm[19:12], a_rec_q.rd, a_rec_q.opcode};
      default:    inst_asm = 32'h0;
    endcase
  end

  // ---- stage B: output holding register ----
  always_comb begin
    out_valid_d   = out_valid_q;
    out_inst_d    = out_inst_q;
    out_pc_d      = out_pc_q;
    out_illegal_d = out_illegal_q;
    illegal_cnt_d = illegal_cnt_q;
    if (b_adv) begin
      out_valid_d = a_valid_q;
    end
    if (a_adv) begin
      out_inst_d    = a_legal_q ? inst_asm : 32'h0;
      out_pc_d      = a_rec_q.pc;
      out_illegal_d = !a_legal_q;
      if (!a_legal_q) begin
        illegal_cnt_d = sat_inc(illegal_cnt_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_valid_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_inst_q    <= 32'h0;
      out_pc_q      <= 32'h0;
      out_illegal_q <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      a_valid_q     <= a_valid_d;
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_pc_q      <= out_pc_d;
      out_illegal_q <= out_illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Stage A payload is qualified by a_valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    a_rec_q   <= a_rec_d;
    a_fmt_q   <= a_fmt_d;
    a_legal_q <= a_legal_d;
  end

  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign out_illegal = out_illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table driven through a scoreboard,
// plus hand sequences for latency, back-pressure, counter saturation and reset.
module tb_inst_encoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst, out_pc;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        d2_in_ready, d2_out_valid, d2_out_illegal;
  logic [31:0] d2_out_inst, d2_out_pc;
  logic [1:0]  d2_illegal_cnt;

  always #5 clock = ~clock;

  inst_encoder #(.CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  inst_encoder #(.CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_pc(in_pc), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_shamt(in_shamt),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_inst(d2_out_inst), .out_pc(d2_out_pc),
    .out_illegal(d2_out_illegal), .illegal_cnt(d2_illegal_cnt)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [31:0] exp_inst;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  vec_t tbl[18];
  exp_t sb[$];
  exp_t cur_exp;
  int   nchecks = 0;
  int   nerrors = 0;
  int   exp_cnt = 0;
  bit   drv_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [4:0] sh,
                              input logic [31:0] ei, input logic el);
    vec_t v;
    v.opcode = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.shamt = sh; v.exp_inst = ei; v.exp_ill = el;
    return v;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_inst", out_inst, e.inst);
          check("out_pc", out_pc, e.pc);
          check("out_illegal", 32'(out_illegal), 32'(e.ill));
          if (e.ill) exp_cnt++;
          check("illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
          check("illegal_cnt_sat2", 32'(d2_illegal_cnt), 32'((exp_cnt > 3) ? 3 : exp_cnt));
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic send(input vec_t v, input logic [31:0] pc);
    bit ok = 0;
    in_opcode = v.opcode; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm; in_shamt = v.shamt; in_pc = pc;
    cur_exp.inst = v.exp_inst; cur_exp.pc = pc; cur_exp.ill = v.exp_ill;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #2;
      if (sb.size() == 0) return;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_drv();
    for (int i = 0; i < 100; i++) begin
      if (drv_done) return;
      @(posedge clock);
      #2;
    end
    check("driver_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    tbl[0]  = mk(7'b0110011, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'h0,        5'd0, 32'h002081B3, 1'b0);
    tbl[1]  = mk(7'b0100011, 5'd31, 5'd1, 5'd2,  3'd2, 7'h00, 32'h8,        5'd0, 32'h0020A423, 1'b0);
    tbl[2]  = mk(7'b1100011, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 32'hFFFFFFFC, 5'd0, 32'hFE208EE3, 1'b0);
    tbl[3]  = mk(7'b0110111, 5'd5,  5'd0, 5'd0,  3'd0, 7'h00, 32'h12345000, 5'd0, 32'h123452B7, 1'b0);
    tbl[4]  = mk(7'b0010011, 5'd4,  5'd3, 5'd0,  3'd5, 7'h20, 32'h0,        5'd2, 32'h4021D213, 1'b0);
    tbl[5]  = mk(7'b1101111, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'h10,       5'd0, 32'h010000EF, 1'b0);
    tbl[6]  = mk(7'b0010111, 5'd2,  5'd0, 5'd0,  3'd0, 7'h00, 32'h1000,     5'd0, 32'h00001117, 1'b0);
    tbl[7]  = mk(7'b0010011, 5'd5,  5'd6, 5'd0,  3'd1, 7'h00, 32'h0,        5'd3, 32'h00331293, 1'b0);
    tbl[8]  = mk(7'b0000011, 5'd7,  5'd2, 5'd31, 3'd2, 7'h00, 32'hFFFFFFFC, 5'd0, 32'hFFC12383, 1'b0);
    tbl[9]  = mk(7'b0010011, 5'd1,  5'd1, 5'd0,  3'd5, 7'h00, 32'h0,        5'd1, 32'h0010D093, 1'b0);
    tbl[10] = mk(7'b1100011, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 32'h3,        5'd0, 32'h0,        1'b1);
    tbl[11] = mk(7'b0110111, 5'd5,  5'd0, 5'd0,  3'd0, 7'h00, 32'h1,        5'd0, 32'h0,        1'b1);
    tbl[12] = mk(7'b0000000, 5'd1,  5'd1, 5'd1,  3'd0, 7'h00, 32'h0,        5'd0, 32'h0,        1'b1);
    tbl[13] = mk(7'b1101111, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'h1,        5'd0, 32'h0,        1'b1);
    tbl[14] = mk(7'b0010011, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'h800,      5'd0, 32'h0,        1'b1);
    tbl[15] = mk(7'b0010011, 5'd1,  5'd1, 5'd0,  3'd1, 7'h20, 32'h0,        5'd1, 32'h0,        1'b1);
    tbl[16] = mk(7'b0010011, 5'd1,  5'd1, 5'd0,  3'd5, 7'h01, 32'h0,        5'd1, 32'h0,        1'b1);
    tbl[17] = mk(7'b1101111, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00200000, 5'd0, 32'h0,        1'b1);

    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5: visible after the second edge following acceptance
    @(posedge clock); #1;
    send(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h5, 5'd0, 32'h00500093, 1'b0), 32'h00000100);
    in_valid = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_inst", out_inst, 32'h00500093);
    drain();

    for (int i = 0; i < 18; i++) send(tbl[i], 32'h1000 + 32'(i) * 4);
    in_valid = 1'b0;
    drain();

    // Back-pressure: 4 back-to-back records with the consumer stalled
    out_ready = 1'b0;
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i], 32'h2000 + 32'(i) * 4);
        in_valid = 1'b0;
        drv_done = 1;
      end
    join_none
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_inst", out_inst, tbl[0].exp_inst);
    held = out_inst;
    @(negedge clock);
    check("stall_hold_inst", out_inst, held);
    check("stall_hold_pc", out_pc, 32'h2000);
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stream_no_gap", 32'(out_valid), 32'd1);
    end
    wait_drv();
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    drv_done = 0;
    fork
      begin
        send(tbl[10], 32'h3000);
        send(tbl[1], 32'h3004);
        in_valid = 1'b0;
        drv_done = 1;
      end
    join_none
    wait_drv();
    @(negedge clock);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_cnt_nonzero", 32'(illegal_cnt != 0), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(tbl[3], 32'h4000);
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("rst2_new_valid", 32'(out_valid), 32'd1);
    check("rst2_new_inst", out_inst, tbl[3].exp_inst);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
